// File: rtl/sobel_sched_pkg.sv
// Shared types and width helpers for the Sobel frame scheduler.
package sobel_sched_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StDone
  } sched_state_e;

  // Counter / index widths; never below 1 bit so degenerate sizes still elaborate.
  function automatic int unsigned col_w(input int unsigned image_width);
    return (image_width > 1) ? $clog2(image_width) : 1;
  endfunction

  function automatic int unsigned row_w(input int unsigned image_height);
    return (image_height > 1) ? $clog2(image_height) : 1;
  endfunction

  function automatic int unsigned id_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping.
module sched_rr_arbiter
  import sobel_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [id_w(NUM_REQ)-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [id_w(NUM_REQ)-1:0]    idx,
  output logic                        any
);

  localparam int unsigned IdW = id_w(NUM_REQ);

  int unsigned cand;

  // Scan the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(rr_ptr) + off) % NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame scheduler sharing one Sobel engine between NUM_REQ pixel sources.
// Grants one source per frame (round-robin), clears the engine, streams a full
// frame and forwards only interior results tagged with the owner ID.
// Optional build macro SOBEL_SCHED_TIMEOUT_EN: abort a frame after TIMEOUT
// consecutive stall cycles and pulse frame_err.
module sobel_frame_scheduler
  import sobel_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned IMAGE_WIDTH  = 128,
  parameter int unsigned IMAGE_HEIGHT = 128,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  input  logic [NUM_REQ-1:0]         src_valid,
  input  logic [PIX_W*NUM_REQ-1:0]   src_pixel,
  output logic [NUM_REQ-1:0]         src_ready,
  output logic                       eng_clr,
  output logic                       eng_valid,
  output logic [PIX_W-1:0]           eng_pixel,
  input  logic                       eng_out_valid,
  input  logic [PIX_W-1:0]           eng_out_pixel,
  output logic                       res_valid,
  output logic [PIX_W-1:0]           res_pixel,
  output logic [id_w(NUM_REQ)-1:0]   res_id,
  output logic                       res_last,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int unsigned ColW = col_w(IMAGE_WIDTH);
  localparam int unsigned RowW = row_w(IMAGE_HEIGHT);
  localparam int unsigned IdW  = id_w(NUM_REQ);

  sched_state_e         state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IdW-1:0]       gidx_q, gidx_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  logic                 drain_q, drain_d;
  logic                 keep_q, last_q;
  logic                 res_valid_q, res_last_q;
  logic [PIX_W-1:0]     res_pixel_q;
  logic [IdW-1:0]       res_id_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IdW-1:0]       arb_idx;
  logic                 arb_any;

  logic                 in_stream, sel_valid, accept;
  logic [PIX_W-1:0]     sel_pixel;
  logic                 col_last, row_last, frame_last, interior;
  logic                 timeout;

  sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  assign in_stream  = (state_q == StStream);
  assign sel_valid  = src_valid[gidx_q];
  assign sel_pixel  = src_pixel[PIX_W*int'(gidx_q) +: PIX_W];
  assign accept     = in_stream & sel_valid;
  assign col_last   = (col_q == ColW'(IMAGE_WIDTH - 1));
  assign row_last   = (row_q == RowW'(IMAGE_HEIGHT - 1));
  assign frame_last = col_last & row_last;
  // Rows 0-1 and columns 0-1 carry stale line-buffer / wrapped-window output.
  assign interior   = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

`ifdef SOBEL_SCHED_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [StallW-1:0] stall_q, stall_d;
  logic              abort_q, abort_d;

  // Fires on the TIMEOUT-th consecutive stalled STREAM cycle.
  assign timeout = in_stream & ~sel_valid & (stall_q == StallW'(TIMEOUT - 1));

  // Stall counter and abort flag next-state.
  always_comb begin
    stall_d = '0;
    if (in_stream && !sel_valid) begin
      stall_d = stall_q + 1'b1;
    end
    abort_d = abort_q;
    if (timeout) begin
      abort_d = 1'b1;
    end else if (state_q == StDone) begin
      abort_d = 1'b0;
    end
  end

  // Stall counter and abort flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign frame_done = (state_q == StDone) & ~abort_q;
  assign frame_err  = (state_q == StDone) & abort_q;
`else
  assign timeout    = 1'b0;
  assign frame_done = (state_q == StDone);
  assign frame_err  = 1'b0;
`endif

  // FSM next-state, pixel position counters and round-robin pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    col_d    = col_q;
    row_d    = row_q;
    drain_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          state_d = StClear;
        end
      end
      StClear: begin
        col_d   = '0;
        row_d   = '0;
        state_d = StStream;
      end
      StStream: begin
        if (accept) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (frame_last) begin
            state_d = StDrain;
          end
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StDrain: begin
        // Two cycles: engine output, then the registered result.
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rr_ptr_d = (gidx_q == IdW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        grant_d  = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      drain_q  <= drain_d;
    end
  end

  // Tag each accepted pixel, then qualify the engine output one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keep_q      <= 1'b0;
      last_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_pixel_q <= '0;
      res_id_q    <= '0;
    end else begin
      keep_q      <= accept & interior;
      last_q      <= accept & frame_last;
      res_valid_q <= eng_out_valid & keep_q;
      res_last_q  <= eng_out_valid & keep_q & last_q;
      if (eng_out_valid && keep_q) begin
        res_pixel_q <= eng_out_pixel;
        res_id_q    <= gidx_q;
      end
    end
  end

  assign grant     = grant_q;
  assign src_ready = in_stream ? grant_q : '0;
  assign eng_clr   = (state_q == StClear);
  assign eng_valid = accept;
  assign eng_pixel = in_stream ? sel_pixel : '0;
  assign res_valid = res_valid_q;
  assign res_pixel = res_pixel_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;
  assign busy      = (state_q != StIdle);

endmodule
